// File: rtl/sic_issue_queue_if.sv
// SIC issue-queue bus bundle.
// Carries the issue-side handshake, the executor start/done handshake, the
// in-flight advertisement, flush and the queue status outputs.
// The queue itself connects through the slave modport; the environment
// (issue stage, executors, bench) uses the master modport.
interface sic_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 64
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // Issue side
    logic             req_instr;
    logic             pkt_valid;
    logic [2:0]       pkt_kind;
    logic [PKT_W-1:0] pkt_data;

    // Executor side
    logic             exec_valid;
    logic [2:0]       exec_kind;
    logic [PKT_W-1:0] exec_data;
    logic             exec_done;

    // In-flight advertisement
    logic             adv_valid;
    logic [PKT_W-1:0] adv_data;

    // Control and status
    logic             flush;
    logic [OCC_W-1:0] occupancy;
    logic             overflow_err;

    modport master (
        input  req_instr,
        output pkt_valid,
        output pkt_kind,
        output pkt_data,
        input  exec_valid,
        input  exec_kind,
        input  exec_data,
        output exec_done,
        input  adv_valid,
        input  adv_data,
        output flush,
        input  occupancy,
        input  overflow_err
    );

    modport slave (
        output req_instr,
        input  pkt_valid,
        input  pkt_kind,
        input  pkt_data,
        output exec_valid,
        output exec_kind,
        output exec_data,
        input  exec_done,
        output adv_valid,
        output adv_data,
        input  flush,
        output occupancy,
        output overflow_err
    );
endinterface

// File: rtl/sic_issue_queue.sv
// SIC issue queue.
// A DEPTH-entry circular FIFO of {kind, payload} packets feeding a single
// in-flight slot. In IDLE the head of the queue is offered to the executors
// with a one-cycle exec_valid pulse and moved into the in-flight register;
// the queue then waits in EXEC until the executor reports exec_done.
// flush empties the queue only; the in-flight packet is untouched.
// overflow_err latches any packet offered while req_instr was low.
module sic_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    sic_issue_queue_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = PKT_W + 3;

    localparam logic [OCC_W-1:0] DEPTH_OCC    = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ZERO     = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE      = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO     = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
    localparam logic [PKT_W-1:0] DATA_ZERO    = {PKT_W{1'b0}};
    localparam logic [2:0]       KIND_IMM     = 3'd2;
    localparam logic [2:0]       KIND_SYSCALL = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Undefined packet classes (5..7) are executed as immediates.
    function automatic logic [2:0] norm_kind(input logic [2:0] kind);
        logic [2:0] res;
        if (kind > KIND_SYSCALL) begin
            res = KIND_IMM;
        end else begin
            res = kind;
        end
        return res;
    endfunction

    // Registered state
    state_t           state_r;
    logic [ENT_W-1:0] fifo_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic [PKT_W-1:0] inflight_r;
    logic             overflow_r;

    // Combinational decode
    logic             req_s;
    logic             push_s;
    logic             drop_s;
    logic             pop_s;
    logic [ENT_W-1:0] head_s;
    logic [2:0]       exec_kind_s;
    logic [PKT_W-1:0] exec_data_s;
    logic             adv_valid_s;
    logic [PKT_W-1:0] adv_data_s;

    // Handshake decode: space/flush gating, push/drop/pop and executor bus.
    always_comb begin
        req_s       = (occ_r < DEPTH_OCC) && !bus.flush;
        push_s      = bus.pkt_valid && req_s;
        drop_s      = bus.pkt_valid && !req_s;
        pop_s       = (state_r == ST_IDLE) && (occ_r != OCC_ZERO) && !bus.flush;
        head_s      = fifo_r[rd_ptr_r];
        exec_kind_s = 3'd0;
        exec_data_s = DATA_ZERO;
        if (pop_s) begin
            exec_kind_s = head_s[ENT_W-1:PKT_W];
            exec_data_s = head_s[PKT_W-1:0];
        end else begin
            exec_kind_s = 3'd0;
            exec_data_s = DATA_ZERO;
        end
        adv_valid_s = (state_r == ST_EXEC);
        if (adv_valid_s) begin
            adv_data_s = inflight_r;
        end else begin
            adv_data_s = DATA_ZERO;
        end
    end

    assign bus.req_instr    = req_s;
    assign bus.exec_valid   = pop_s;
    assign bus.exec_kind    = exec_kind_s;
    assign bus.exec_data    = exec_data_s;
    assign bus.adv_valid    = adv_valid_s;
    assign bus.adv_data     = adv_data_s;
    assign bus.occupancy    = occ_r;
    assign bus.overflow_err = overflow_r;

    // Packet storage: write the normalised packet at the tail on enqueue.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= {norm_kind(bus.pkt_kind), bus.pkt_data};
        end
    end

    // Queue bookkeeping: pointers and occupancy, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            occ_r    <= OCC_ZERO;
        end else if (bus.flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            occ_r    <= OCC_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Dispatch FSM: IDLE pops the head into the in-flight slot, EXEC waits for commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            inflight_r <= DATA_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        inflight_r <= head_s[PKT_W-1:0];
                        state_r    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.exec_done) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag: a packet offered with no room is lost for good.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sic_issue_queue.sv
// Directed self-checking bench for sic_issue_queue (DEPTH=4, PKT_W=64).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge of the same cycle.
module tb_sic_issue_queue;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] bk  [4];
    logic [2:0] bek [4];

    sic_issue_queue_if #(.DEPTH(4), .PKT_W(64)) bus ();

    sic_issue_queue #(.DEPTH(4), .PKT_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Present n packets back-to-back into an empty, idle queue with exec_done low.
    task automatic send_burst(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.pkt_valid = 1'b1;
            bus.pkt_kind  = bk[i % 4];
            bus.pkt_data  = base + 64'(i);
            samp();
            check_eq("burst_req", {63'd0, bus.req_instr}, (i < 5) ? 64'd1 : 64'd0);
            check_eq("burst_occ", 64'(bus.occupancy), (i == 0) ? 64'd0 : (i == 1) ? 64'd1 : 64'(i - 1));
            if (i == 1) begin
                check_eq("burst_xv", {63'd0, bus.exec_valid}, 64'd1);
                check_eq("burst_xk", 64'(bus.exec_kind), 64'(bek[0]));
                check_eq("burst_xd", bus.exec_data, base);
            end
        end
        tick();
        bus.pkt_valid = 1'b0;
        bus.pkt_kind  = 3'd0;
        bus.pkt_data  = 64'd0;
    endtask

    // Commit the in-flight packet and expect the next one to be dispatched.
    task automatic expect_dispatch(input logic [2:0] k, input logic [63:0] d);
        tick();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        samp();
        check_eq("disp_xv", {63'd0, bus.exec_valid}, 64'd1);
        check_eq("disp_xk", 64'(bus.exec_kind), 64'(k));
        check_eq("disp_xd", bus.exec_data, d);
        tick();
        samp();
        check_eq("disp_av", {63'd0, bus.adv_valid}, 64'd1);
        check_eq("disp_ad", bus.adv_data, d);
        check_eq("disp_xv0", {63'd0, bus.exec_valid}, 64'd0);
    endtask

    // Commit the last in-flight packet with an empty queue.
    task automatic finish_inflight();
        tick();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        samp();
        check_eq("fin_av", {63'd0, bus.adv_valid}, 64'd0);
        check_eq("fin_ad", bus.adv_data, 64'd0);
        check_eq("fin_xv", {63'd0, bus.exec_valid}, 64'd0);
        check_eq("fin_occ", 64'(bus.occupancy), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.pkt_kind  = 3'd0;
        bus.pkt_data  = 64'd0;
        bus.exec_done = 1'b0;
        bus.flush     = 1'b0;

        // Reset values while reset is held
        samp();
        check_eq("rst_req", {63'd0, bus.req_instr}, 64'd1);
        check_eq("rst_xv", {63'd0, bus.exec_valid}, 64'd0);
        check_eq("rst_av", {63'd0, bus.adv_valid}, 64'd0);
        check_eq("rst_ad", bus.adv_data, 64'd0);
        check_eq("rst_occ", 64'(bus.occupancy), 64'd0);
        check_eq("rst_ovf", {63'd0, bus.overflow_err}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Single packet: 1-cycle dispatch latency, advertisement until exec_done
        tick();
        bus.pkt_valid = 1'b1;
        bus.pkt_kind  = 3'd1;
        bus.pkt_data  = 64'hA5;
        samp();
        check_eq("lat_c0_xv", {63'd0, bus.exec_valid}, 64'd0);
        tick();
        bus.pkt_valid = 1'b0;
        bus.pkt_kind  = 3'd0;
        bus.pkt_data  = 64'd0;
        samp();
        check_eq("lat_c1_xv", {63'd0, bus.exec_valid}, 64'd1);
        check_eq("lat_c1_xk", 64'(bus.exec_kind), 64'd1);
        check_eq("lat_c1_xd", bus.exec_data, 64'hA5);
        check_eq("lat_c1_av", {63'd0, bus.adv_valid}, 64'd0);
        tick();
        samp();
        check_eq("lat_c2_xv", {63'd0, bus.exec_valid}, 64'd0);
        check_eq("lat_c2_xk", 64'(bus.exec_kind), 64'd0);
        check_eq("lat_c2_xd", bus.exec_data, 64'd0);
        check_eq("lat_c2_av", {63'd0, bus.adv_valid}, 64'd1);
        check_eq("lat_c2_ad", bus.adv_data, 64'hA5);
        tick();
        samp();
        check_eq("lat_c3_ad", bus.adv_data, 64'hA5);
        tick();
        bus.exec_done = 1'b1;
        samp();
        check_eq("lat_done_av", {63'd0, bus.adv_valid}, 64'd1);
        tick();
        bus.exec_done = 1'b0;
        samp();
        check_eq("lat_post_av", {63'd0, bus.adv_valid}, 64'd0);
        check_eq("lat_post_ad", bus.adv_data, 64'd0);
        // exec_done in IDLE has no effect
        tick();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        samp();
        check_eq("idle_done_av", {63'd0, bus.adv_valid}, 64'd0);
        check_eq("idle_done_xv", {63'd0, bus.exec_valid}, 64'd0);

        // Overflow: 6 back-to-back packets, 1 in flight, 4 queued, 1 dropped
        bk  = '{3'd0, 3'd0, 3'd0, 3'd0};
        bek = '{3'd0, 3'd0, 3'd0, 3'd0};
        send_burst(6, 64'h100);
        samp();
        check_eq("ovf_occ", 64'(bus.occupancy), 64'd4);
        check_eq("ovf_req", {63'd0, bus.req_instr}, 64'd0);
        check_eq("ovf_err", {63'd0, bus.overflow_err}, 64'd1);
        check_eq("ovf_ad", bus.adv_data, 64'h100);
        for (int i = 1; i <= 4; i++) begin
            expect_dispatch(3'd0, 64'h100 + 64'(i));
        end
        finish_inflight();

        // Kind normalisation and pointer wrap over three passes
        bk  = '{3'd0, 3'd3, 3'd4, 3'd7};
        bek = '{3'd0, 3'd3, 3'd4, 3'd2};
        for (int p = 0; p < 3; p++) begin
            send_burst(4, 64'h200 + 64'(p * 16));
            samp();
            check_eq("wrap_occ", 64'(bus.occupancy), 64'd3);
            for (int i = 1; i < 4; i++) begin
                expect_dispatch(bek[i], 64'h200 + 64'(p * 16 + i));
            end
            finish_inflight();
        end

        // Flush with a packet in flight and three queued
        bk  = '{3'd5, 3'd6, 3'd1, 3'd0};
        bek = '{3'd2, 3'd2, 3'd1, 3'd0};
        send_burst(4, 64'h300);
        samp();
        check_eq("fl_occ_pre", 64'(bus.occupancy), 64'd3);
        tick();
        bus.flush = 1'b1;
        samp();
        check_eq("fl_req", {63'd0, bus.req_instr}, 64'd0);
        check_eq("fl_av", {63'd0, bus.adv_valid}, 64'd1);
        tick();
        bus.flush = 1'b0;
        samp();
        check_eq("fl_occ", 64'(bus.occupancy), 64'd0);
        check_eq("fl_av_post", {63'd0, bus.adv_valid}, 64'd1);
        check_eq("fl_ad_post", bus.adv_data, 64'h300);
        finish_inflight();
        tick();
        samp();
        check_eq("fl_no_disp", {63'd0, bus.exec_valid}, 64'd0);

        // Flush together with exec_done
        bk  = '{3'd1, 3'd1, 3'd1, 3'd1};
        bek = '{3'd1, 3'd1, 3'd1, 3'd1};
        send_burst(3, 64'h400);
        samp();
        check_eq("fd_occ_pre", 64'(bus.occupancy), 64'd2);
        tick();
        bus.flush     = 1'b1;
        bus.exec_done = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.exec_done = 1'b0;
        samp();
        check_eq("fd_av", {63'd0, bus.adv_valid}, 64'd0);
        check_eq("fd_occ", 64'(bus.occupancy), 64'd0);
        check_eq("fd_xv", {63'd0, bus.exec_valid}, 64'd0);

        // Reset in the middle of EXEC with two queued
        bk  = '{3'd4, 3'd4, 3'd4, 3'd4};
        bek = '{3'd4, 3'd4, 3'd4, 3'd4};
        send_burst(3, 64'h500);
        samp();
        check_eq("mr_occ_pre", 64'(bus.occupancy), 64'd2);
        check_eq("mr_ovf_pre", {63'd0, bus.overflow_err}, 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mr_occ", 64'(bus.occupancy), 64'd0);
        check_eq("mr_av", {63'd0, bus.adv_valid}, 64'd0);
        check_eq("mr_ad", bus.adv_data, 64'd0);
        check_eq("mr_xv", {63'd0, bus.exec_valid}, 64'd0);
        check_eq("mr_req", {63'd0, bus.req_instr}, 64'd1);
        check_eq("mr_ovf", {63'd0, bus.overflow_err}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.pkt_valid = 1'b1;
        bus.pkt_kind  = 3'd3;
        bus.pkt_data  = 64'h5A;
        samp();
        check_eq("mr_c0_xv", {63'd0, bus.exec_valid}, 64'd0);
        tick();
        bus.pkt_valid = 1'b0;
        bus.pkt_kind  = 3'd0;
        bus.pkt_data  = 64'd0;
        samp();
        check_eq("mr_c1_xv", {63'd0, bus.exec_valid}, 64'd1);
        check_eq("mr_c1_xk", 64'(bus.exec_kind), 64'd3);
        check_eq("mr_c1_xd", bus.exec_data, 64'h5A);
        tick();
        finish_inflight();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
